// File: rtl/uart_tx_ctrl.sv
// Sends a captured 16-bit ALU result to the UART transmitter as two bytes, LSB first.
// Owns the tx_start/tx_busy handshake, with settle/inter-byte delays and ack-timeout retry.
module uart_tx_ctrl #(
  parameter int WAIT_FOR_REGISTER_DELAY = 100,
  parameter int INTER_BYTE_DELAY        = 100,
  parameter int ACK_TIMEOUT             = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [15:0] result,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  LED
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    REGISTER = 4'd1,
    SEND_LSB = 4'd2,
    ACK_LSB  = 4'd3,
    WAIT_LSB = 4'd4,
    GAP      = 4'd5,
    SEND_MSB = 4'd6,
    ACK_MSB  = 4'd7,
    WAIT_MSB = 4'd8,
    DONE     = 4'd9
  } state_t;

  localparam logic [31:0] REG_LAST = 32'(WAIT_FOR_REGISTER_DELAY - 1);
  localparam logic [31:0] GAP_LAST = 32'(INTER_BYTE_DELAY - 1);
  localparam logic [31:0] ACK_LAST = 32'(ACK_TIMEOUT - 1);

  // Plain vector so codes 10-15 are representable and recover through default.
  logic [3:0]  state;
  logic [15:0] result_reg;
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      result_reg <= '0;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      case (state)
        IDLE: begin
          if (trigger) begin
            result_reg <= result;
            state      <= REGISTER;
            cnt        <= '0;
          end
        end
        REGISTER: begin
          if (cnt == REG_LAST) begin
            state <= SEND_LSB;
            cnt   <= '0;
          end
        end
        SEND_LSB: begin
          state <= ACK_LSB;
          cnt   <= '0;
        end
        ACK_LSB: begin
          if (tx_busy) begin
            state <= WAIT_LSB;
            cnt   <= '0;
          end else if (cnt == ACK_LAST) begin
            state <= SEND_LSB;
            cnt   <= '0;
          end
        end
        WAIT_LSB: begin
          if (!tx_busy) begin
            state <= GAP;
            cnt   <= '0;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= SEND_MSB;
            cnt   <= '0;
          end
        end
        SEND_MSB: begin
          state <= ACK_MSB;
          cnt   <= '0;
        end
        ACK_MSB: begin
          if (tx_busy) begin
            state <= WAIT_MSB;
            cnt   <= '0;
          end else if (cnt == ACK_LAST) begin
            state <= SEND_MSB;
            cnt   <= '0;
          end
        end
        WAIT_MSB: begin
          if (!tx_busy) begin
            state <= DONE;
            cnt   <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode the state register only; nothing flows through from the inputs.
  assign tx_start = (state == SEND_LSB) || (state == SEND_MSB);
  assign tx_data  = (state <= WAIT_LSB) ? result_reg[7:0] : result_reg[15:8];
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign LED      = state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected tx_start/done events,
// a negedge monitor pops and compares byte and cycle of each event.
module tb_uart_tx_ctrl;

  localparam int D    = 4;
  localparam int G    = 3;
  localparam int T    = 5;
  localparam int HOLD = 10;
  // tx_start cycle to the edge where WAIT first samples tx_busy low
  localparam int LAT  = HOLD + 2;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] result = 16'h0000;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic [3:0]  LED;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   ignore_n = 0;
  exp_t q[$];

  uart_tx_ctrl #(
    .WAIT_FOR_REGISTER_DELAY(D),
    .INTER_BYTE_DELAY(G),
    .ACK_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .result(result),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .busy(busy),
    .done(done),
    .LED(LED)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transmitter model: busy one cycle after tx_start, held HOLD cycles.
  initial begin : tx_model
    forever begin
      @(negedge clk);
      if (tx_start && reset) begin
        if (ignore_n > 0) begin
          ignore_n--;
        end else begin
          @(posedge clk);
          #1 tx_busy = 1'b1;
          repeat (HOLD) @(posedge clk);
          #1 tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic mon_event(input bit is_done);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required none",
               is_done ? "done" : "tx_start", cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(is_done), 32'(e.is_done));
      chk(is_done ? "done_cycle" : "start_cycle", cyc, e.cyc);
      if (!is_done) chk("start_tx_data", 32'(tx_data), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (tx_start) mon_event(1'b0);
      if (done) mon_event(1'b1);
    end
  end

  task automatic push_txn(input int e0, input logic [15:0] r, input bit retry, input bit with_done);
    int s1;
    int s2;
    s1 = e0 + D;
    q.push_back('{1'b0, r[7:0], s1});
    if (retry) begin
      s1 = s1 + 1 + T;
      q.push_back('{1'b0, r[7:0], s1});
    end
    s2 = s1 + LAT + G;
    q.push_back('{1'b0, r[15:8], s2});
    if (with_done) q.push_back('{1'b1, 8'h00, s2 + LAT});
  endtask

  task automatic start(input logic [15:0] r, output int e0);
    @(negedge clk);
    result  = r;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    e0      = cyc;
    trigger = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_queue_drained"}, 32'(q.size()), 32'd0);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    q.delete();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int e0;
    int e1;
    int n;

    // reset state
    #12;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_led", 32'(LED), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_led", 32'(LED), 32'd0);

    // basic send
    start(16'hA5C3, e0);
    push_txn(e0, 16'hA5C3, 1'b0, 1'b1);
    chk("basic_reg_led", 32'(LED), 32'd1);
    chk("basic_reg_busy", 32'(busy), 32'd1);
    wait_cyc(e0 + 6);
    chk("basic_wait_lsb_led", 32'(LED), 32'd4);
    chk("basic_wait_lsb_data", 32'(tx_data), 32'hC3);
    wait_cyc(e0 + D + LAT);
    chk("basic_gap_led", 32'(LED), 32'd5);
    chk("basic_gap_data", 32'(tx_data), 32'hA5);
    wait_drain("basic", 80);
    chk("basic_end_led", 32'(LED), 32'd0);

    // capture isolation
    start(16'hA5C3, e0);
    result = 16'hFFFF;
    push_txn(e0, 16'hA5C3, 1'b0, 1'b1);
    wait_cyc(e0 + D + LAT + 1);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_drain("isolation", 80);
    repeat (5) @(negedge clk);
    chk("isolation_no_second_txn", 32'(LED), 32'd0);

    // ack timeout and retry
    ignore_n = 1;
    start(16'hA5C3, e0);
    push_txn(e0, 16'hA5C3, 1'b1, 1'b1);
    wait_cyc(e0 + D + 1);
    chk("retry_ack_entry_led", 32'(LED), 32'd3);
    wait_cyc(e0 + D + T);
    chk("retry_ack_last_led", 32'(LED), 32'd3);
    wait_drain("retry", 80);

    // reset mid WAIT_MSB
    result = 16'h0000;
    start(16'hA5C3, e0);
    push_txn(e0, 16'hA5C3, 1'b0, 1'b0);
    wait_cyc(e0 + D + LAT + G + 3);
    chk("rstmid_wait_msb_led", 32'(LED), 32'd8);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_tx_start", 32'(tx_start), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_tx_data", 32'(tx_data), 32'd0);
    chk("rstmid_led", 32'(LED), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rstmid_bytes_seen", 32'(q.size()), 32'd0);
    q.delete();
    n = 0;
    while (tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    start(16'h0102, e0);
    push_txn(e0, 16'h0102, 1'b0, 1'b1);
    wait_drain("rstmid_new", 80);

    // back-to-back with trigger held high
    @(negedge clk);
    result  = 16'h1234;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    e1 = e0 + D + 2 * LAT + G + 2;
    push_txn(e0, 16'h1234, 1'b0, 1'b1);
    push_txn(e1, 16'h1234, 1'b0, 1'b1);
    wait_cyc(e1 - 1);
    chk("b2b_idle_between", 32'(LED), 32'd0);
    wait_cyc(e1);
    chk("b2b_second_register", 32'(LED), 32'd1);
    trigger = 1'b0;
    wait_drain("b2b", 120);
    repeat (4) @(negedge clk);
    chk("b2b_no_third", 32'(LED), 32'd0);

    // illegal state recovery
    @(negedge clk);
    force dut.state = 4'hC;
    #1 release dut.state;
    @(posedge clk);
    #1;
    chk("illegal_led", 32'(LED), 32'd0);
    chk("illegal_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
